e10_mac_csr_init_arbiter: RTL

//  Owns the 10G MAC Avalon-MM CSR port (csr_clk domain). After reset, or on init_start, it writes a

---
 rtl/e10_mac_csr_init_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/e10_mac_csr_init_arbiter.sv
// 10G MAC CSR port owner: replays a static {addr,data} init table into the MAC, then passes
// host Avalon-MM traffic through, with a waitrequest timeout on every access.
//
//   state | meaning
//   IDLE  | after reset; host blocked; waiting for auto-start or init_start
//   INIT  | table walk owns the MAC; host blocked
//   READY | host_* passed through to mac_csr_*
module e10_mac_csr_init_arbiter #(
    parameter int          NUM_ENTRIES = 8,
    parameter bit          AUTO_INIT   = 1'b1,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] TO_RDATA    = 32'hDEAD_C0DE
) (
    input  logic                      csr_clk,
    input  logic                      csr_rst,
    input  logic [NUM_ENTRIES*43-1:0] cfg_table,
    input  logic                      init_start,
    output logic                      init_busy,
    output logic                      init_done,
    output logic                      init_error,
    output logic                      host_timeout,
    input  logic                      host_read,
    input  logic                      host_write,
    input  logic [9:0]                host_address,
    input  logic [31:0]               host_writedata,
    output logic [31:0]               host_readdata,
    output logic                      host_waitrequest,
    output logic                      mac_csr_read,
    output logic                      mac_csr_write,
    output logic [9:0]                mac_csr_address,
    output logic [31:0]               mac_csr_writedata,
    input  logic [31:0]               mac_csr_readdata,
    input  logic                      mac_csr_waitrequest
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [15:0]      to_cnt;
    logic             to_resp;
    logic             start_pend;

    logic [42:0] entry [NUM_ENTRIES];
    logic [42:0] cur_entry;

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        assign entry[gi] = cfg_table[43*gi +: 43];
    end

    assign cur_entry = entry[idx];
    assign init_busy = (state == ST_INIT);

    // to_resp marks the single cycle that completes a timed-out host access locally
    always_comb begin
        mac_csr_read      = 1'b0;
        mac_csr_write     = 1'b0;
        mac_csr_address   = '0;
        mac_csr_writedata = '0;
        host_waitrequest  = 1'b1;
        host_readdata     = '0;
        case (state)
            ST_INIT: begin
                mac_csr_write     = cur_entry[42];
                mac_csr_address   = cur_entry[41:32];
                mac_csr_writedata = cur_entry[31:0];
            end
            ST_READY: begin
                if (to_resp) begin
                    host_waitrequest = 1'b0;
                    host_readdata    = TO_RDATA;
                end else begin
                    mac_csr_read      = host_read;
                    mac_csr_write     = host_write;
                    mac_csr_address   = host_address;
                    mac_csr_writedata = host_writedata;
                    host_readdata     = mac_csr_readdata;
                    host_waitrequest  = (host_read | host_write) ? mac_csr_waitrequest : 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic mac_strobe;
    logic mac_stall;
    logic mac_done;
    logic to_hit;
    logic last_idx;
    logic init_adv;
    logic host_free;
    logic start_req;

    assign mac_strobe = mac_csr_read | mac_csr_write;
    assign mac_stall  = mac_strobe & mac_csr_waitrequest;
    assign mac_done   = mac_strobe & ~mac_csr_waitrequest;
    assign to_hit     = mac_stall & (to_cnt == 16'(TIMEOUT - 1));
    assign last_idx   = (idx == IDX_W'(NUM_ENTRIES - 1));
    assign init_adv   = cur_entry[42] ? mac_done : 1'b1;
    // a pending restart may only take the MAC once the host is between accesses
    assign host_free  = ~(host_read | host_write) | to_resp | mac_done;
    assign start_req  = init_start | start_pend;

    always_ff @(posedge csr_clk) begin
        if (csr_rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            to_cnt       <= '0;
            to_resp      <= 1'b0;
            start_pend   <= 1'b0;
            init_done    <= 1'b0;
            init_error   <= 1'b0;
            host_timeout <= 1'b0;
        end else begin
            to_resp <= 1'b0;
            if (mac_stall && !to_hit) to_cnt <= to_cnt + 16'd1;
            else                      to_cnt <= '0;

            case (state)
                ST_IDLE: begin
                    if (AUTO_INIT || init_start) begin
                        state      <= ST_INIT;
                        idx        <= '0;
                        init_done  <= 1'b0;
                        init_error <= 1'b0;
                        start_pend <= 1'b0;
                    end
                end
                ST_INIT: begin
                    if (to_hit) begin
                        state      <= ST_READY;
                        init_error <= 1'b1;
                    end else if (init_adv) begin
                        if (last_idx) begin
                            state     <= ST_READY;
                            init_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (to_hit) begin
                        to_resp      <= 1'b1;
                        host_timeout <= 1'b1;
                    end
                    if (start_req && host_free) begin
                        state      <= ST_INIT;
                        idx        <= '0;
                        init_done  <= 1'b0;
                        init_error <= 1'b0;
                        start_pend <= 1'b0;
                    end else if (init_start) begin
                        start_pend <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
